// File: rtl/pgm_rom_loader.sv
// ----------------------------------------------------------------------------
// pgm_rom_loader
//
// ROM download sequencer between the MiSTer ioctl stream and the shared SDRAM
// controller. Each 16-bit ioctl word is mapped to an SDRAM byte address by
// region (latched ioctl_index) and queued in a small FIFO. The queued words
// are then issued one at a time as write requests over a req/ack handshake.
// The PGM core is held in reset until every accepted word has been committed.
//
// Parameters
//   DEPTH           FIFO entries (power of two, >= 2)
//   BASE0..BASE3    SDRAM byte base of regions 0..3
//   RSIZE           byte size of every region
//
// Ports
//   clk             single clock, rising edge
//   reset           synchronous, active-high
//   ioctl_download  download active (level)
//   ioctl_wr        one-cycle write strobe
//   ioctl_addr      byte address within the file (bit 0 ignored)
//   ioctl_dout      data word
//   ioctl_index     region select, latched when a download starts
//   ioctl_wait      back-pressure to the HPS
//   sdr_req         write request, held until sdr_ack is sampled
//   sdr_ack         request accepted, one-cycle pulse
//   sdr_addr        SDRAM byte address (bit 0 always 0)
//   sdr_din         SDRAM write data
//   core_reset      hold the PGM core in reset
//   done            one-cycle pulse when the load is complete
//   overflow        sticky: a write was dropped because the FIFO was full
//   range_err       sticky: a write was dropped for a bad index or address
// ----------------------------------------------------------------------------
module pgm_rom_loader #(
   parameter int unsigned DEPTH = 4,
   parameter logic [24:0] BASE0 = 25'h0000000,
   parameter logic [24:0] BASE1 = 25'h0400000,
   parameter logic [24:0] BASE2 = 25'h0800000,
   parameter logic [24:0] BASE3 = 25'h1000000,
   parameter logic [24:0] RSIZE = 25'h0400000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [26:0] ioctl_addr,
   input  logic [15:0] ioctl_dout,
   input  logic [7:0]  ioctl_index,
   output logic        ioctl_wait,
   output logic        sdr_req,
   input  logic        sdr_ack,
   output logic [24:0] sdr_addr,
   output logic [15:0] sdr_din,
   output logic        core_reset,
   output logic        done,
   output logic        overflow,
   output logic        range_err
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] WAIT_CNT = CW'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [24:0] addr;
      logic [15:0] data;
   } entry_t;

   // Control state
   state_t        state_q, state_d;
   logic          dl_q;
   logic [7:0]    idx_q, idx_d;
   logic          overflow_q, overflow_d;
   logic          range_err_q, range_err_d;
   logic          done_q, done_d;

   // FIFO
   entry_t        fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Request stage
   logic          req_q, req_d;
   logic [24:0]   addr_q, addr_d;
   logic [15:0]   din_q, din_d;

   // Helpers
   logic          dl_rise;
   logic          fifo_empty;
   logic          fifo_full;
   logic          in_range;
   logic          wr_active;
   logic          push;
   logic          pop;
   logic [24:0]   base_sel;
   entry_t        push_entry;
   entry_t        head;

   // Bit 0 of the file address selects a byte inside the word and plays no
   // part in the SDRAM word address.
   logic          unused_addr_bit;
   assign unused_addr_bit = ioctl_addr[0];

   assign dl_rise    = ioctl_download & ~dl_q;
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_CNT);
   assign in_range   = (idx_q < 8'd4) && (ioctl_addr[26:25] == 2'b00) &&
                       (ioctl_addr[24:0] < RSIZE);
   assign wr_active  = (state_q == S_LOAD) && ioctl_wr;

   // The request register only reloads while it is empty, so a pop frees a
   // FIFO slot in the same cycle a full FIFO accepts a new word.
   assign pop  = ~req_q & ~fifo_empty;
   assign push = wr_active & in_range & (~fifo_full | pop);
   assign head = fifo_mem[rd_ptr_q];

   always_comb begin
      case (idx_q[1:0])
         2'd0:    base_sel = BASE0;
         2'd1:    base_sel = BASE1;
         2'd2:    base_sel = BASE2;
         default: base_sel = BASE3;
      endcase
   end

   // 25-bit sum, wraps modulo 2^25 by construction.
   assign push_entry.addr = base_sel + {ioctl_addr[24:1], 1'b0};
   assign push_entry.data = ioctl_dout;

   // NOTE: every variable assigned here gets a default first, so no path
   // through the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      overflow_d  = overflow_q;
      range_err_d = range_err_q;
      done_d      = 1'b0;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      req_d       = req_q;
      addr_d      = addr_q;
      din_d       = din_q;

      // Sequencer. A new download (from IDLE or while still draining the
      // previous one) latches its region and starts with clean flags.
      case (state_q)
         S_IDLE: begin
            if (dl_rise) begin
               state_d     = S_LOAD;
               idx_d       = ioctl_index;
               overflow_d  = 1'b0;
               range_err_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (!ioctl_download) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (dl_rise) begin
               state_d     = S_LOAD;
               idx_d       = ioctl_index;
               overflow_d  = 1'b0;
               range_err_d = 1'b0;
            end else if (fifo_empty && !req_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Dropped writes only happen in LOAD, so they never collide with the
      // flag clear above.
      if (wr_active) begin
         if (!in_range)                 range_err_d = 1'b1;
         else if (fifo_full && !pop)    overflow_d  = 1'b1;
      end

      // FIFO bookkeeping
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Request stage: hold until ack, then stay idle for one cycle before
      // the next head is loaded. Ack without a pending request is ignored.
      if (req_q) begin
         if (sdr_ack) req_d = 1'b0;
      end else if (pop) begin
         req_d  = 1'b1;
         addr_d = head.addr;
         din_d  = head.data;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         dl_q        <= 1'b0;
         idx_q       <= '0;
         overflow_q  <= 1'b0;
         range_err_q <= 1'b0;
         done_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         req_q       <= 1'b0;
         addr_q      <= '0;
         din_q       <= '0;
      end else begin
         state_q     <= state_d;
         dl_q        <= ioctl_download;
         idx_q       <= idx_d;
         overflow_q  <= overflow_d;
         range_err_q <= range_err_d;
         done_q      <= done_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         req_q       <= req_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
      end
   end

   // NOTE: the storage array has no reset; the pointers and count define
   // which entries are valid, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= push_entry;
   end

   assign ioctl_wait = (count_q >= WAIT_CNT);
   assign sdr_req    = req_q;
   assign sdr_addr   = addr_q;
   assign sdr_din    = din_q;
   assign core_reset = (state_q != S_IDLE);
   assign done       = done_q;
   assign overflow   = overflow_q;
   assign range_err  = range_err_q;

endmodule

// File: tb/tb_pgm_rom_loader.sv
// ----------------------------------------------------------------------------
// tb_pgm_rom_loader
//
// Self-checking bench for pgm_rom_loader. Stimulus pushes the expected SDRAM
// writes into a queue; a monitor pops and compares at every req/ack
// handshake. Directed sequences cover reset, latency, back-pressure,
// overflow, range errors, re-download and mid-load reset; a randomized phase
// follows.
// ----------------------------------------------------------------------------
module tb_pgm_rom_loader;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [24:0] a;
      logic [15:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [26:0] ioctl_addr;
   logic [15:0] ioctl_dout;
   logic [7:0]  ioctl_index;
   logic        ioctl_wait;
   logic        sdr_req;
   logic        sdr_ack;
   logic [24:0] sdr_addr;
   logic [15:0] sdr_din;
   logic        core_reset;
   logic        done;
   logic        overflow;
   logic        range_err;

   logic auto_ack   = 1'b0;
   logic auto_ack_v = 1'b0;
   logic man_ack    = 1'b0;

   int   checks   = 0;
   int   failures = 0;
   int   done_cnt = 0;
   int   cur_idx  = 0;
   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   assign sdr_ack = auto_ack ? auto_ack_v : man_ack;

   pgm_rom_loader #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_index    (ioctl_index),
      .ioctl_wait     (ioctl_wait),
      .sdr_req        (sdr_req),
      .sdr_ack        (sdr_ack),
      .sdr_addr       (sdr_addr),
      .sdr_din        (sdr_din),
      .core_reset     (core_reset),
      .done           (done),
      .overflow       (overflow),
      .range_err      (range_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference mapping: region base plus word-aligned offset, 25-bit wrap.
   function automatic logic [24:0] base_of(input int idx);
      case (idx)
         0:       return 25'h0000000;
         1:       return 25'h0400000;
         2:       return 25'h0800000;
         3:       return 25'h1000000;
         default: return 25'h0000000;
      endcase
   endfunction

   function automatic logic [24:0] exp_addr(input int idx, input logic [26:0] a);
      logic [24:0] off;
      off = a[24:0] & 25'h1FFFFFE;
      return base_of(idx) + off;
   endfunction

   function automatic bit in_range(input int idx, input logic [26:0] a);
      return (idx >= 0) && (idx < 4) && (a[26:25] == 2'b00) && (a[24:0] < 25'h0400000);
   endfunction

   // Random SDRAM acceptance, driven away from the clock edge.
   always @(posedge clk) begin
      #2;
      auto_ack_v = auto_ack && sdr_req && ($urandom_range(0, 2) == 0);
   end

   // Monitor: handshake scoreboard, request hold rules, done pulses.
   logic        prev_req = 1'b0;
   logic        prev_ack = 1'b0;
   logic [24:0] prev_addr = '0;
   logic [15:0] prev_din = '0;

   always @(negedge clk) begin
      if (reset) begin
         prev_req = 1'b0;
         prev_ack = 1'b0;
      end else begin
         if (done) begin
            done_cnt++;
            check("core_reset low while done", core_reset, 1'b0);
         end
         if (prev_req && prev_ack) begin
            check("req low after ack", sdr_req, 1'b0);
         end else if (prev_req && sdr_req) begin
            check("sdr_addr held", sdr_addr, prev_addr);
            check("sdr_din held", sdr_din, prev_din);
         end
         if (sdr_req && sdr_ack) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected write: addr 0x%0h data 0x%0h, none expected", sdr_addr, sdr_din);
            end else begin
               mon_e = sb.pop_front();
               check("sdr_addr", sdr_addr, mon_e.a);
               check("sdr_din", sdr_din, mon_e.d);
            end
         end
         prev_req  = sdr_req;
         prev_ack  = sdr_ack;
         prev_addr = sdr_addr;
         prev_din  = sdr_din;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " sdr_req"},    sdr_req,    1'b0);
      check({tag, " sdr_addr"},   sdr_addr,   25'h0);
      check({tag, " sdr_din"},    sdr_din,    16'h0);
      check({tag, " core_reset"}, core_reset, 1'b0);
      check({tag, " done"},       done,       1'b0);
      check({tag, " overflow"},   overflow,   1'b0);
      check({tag, " range_err"},  range_err,  1'b0);
      check({tag, " ioctl_wait"}, ioctl_wait, 1'b0);
   endtask

   task automatic start_dl(input int idx);
      check("core_reset before download", core_reset, 1'b0);
      ioctl_index    = 8'(idx);
      ioctl_download = 1'b1;
      cur_idx        = idx;
      tick();
      check("core_reset on download rise", core_reset, 1'b1);
      check("overflow cleared at start", overflow, 1'b0);
      check("range_err cleared at start", range_err, 1'b0);
   endtask

   task automatic write(input logic [26:0] a, input logic [15:0] d, input bit keep);
      exp_t e;
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      if (keep) begin
         e.a = exp_addr(cur_idx, a);
         e.d = d;
         sb.push_back(e);
      end
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int start;
      int n;
      start = done_cnt;
      n = 0;
      ioctl_download = 1'b0;
      while (done_cnt == start && n < 400) begin
         tick();
         n++;
      end
      check({tag, " done seen"}, (done_cnt != start), 1'b1);
      ticks(3);
      check({tag, " single done pulse"}, done_cnt - start, 1);
      check({tag, " core_reset released"}, core_reset, 1'b0);
      check({tag, " scoreboard drained"}, sb.size(), 0);
   endtask

   task automatic wait_no_wait();
      int n;
      n = 0;
      while (ioctl_wait && n < 100) begin
         tick();
         n++;
      end
      check("ioctl_wait releases", ioctl_wait, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] dv;
      logic [26:0] a;
      int          d0;
      int          idx;
      int          n;
      int          r;
      bit          keep;
      bit          exp_rerr;

      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      ioctl_index    = '0;
      ticks(3);
      check_reset_vals("reset");
      reset = 1'b0;
      tick();

      // Single word: region 1, offset 0x10
      auto_ack = 1'b0;
      start_dl(1);
      write(27'h0000010, 16'hBEEF, 1'b1);
      check("single req not yet", sdr_req, 1'b0);
      tick();
      check("single req after k+1", sdr_req, 1'b1);
      check("single sdr_addr", sdr_addr, 25'h0400010);
      check("single sdr_din", sdr_din, 16'hBEEF);
      ticks(3);
      check("single req held without ack", sdr_req, 1'b1);
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      check("single req drops on ack", sdr_req, 1'b0);
      wait_done("single");

      // Stall: 8 back-to-back writes, no ack. Word 0 moves to the request
      // register one edge after capture, so FIFO occupancy after write i is
      // 1,1,2,3,4 then full; writes 5..7 are dropped.
      start_dl(2);
      for (int i = 0; i < 8; i++) begin
         dv = 16'($urandom);
         write(27'h0000100 + 27'(2 * i), dv, (i < 5));
         check($sformatf("stall wait after write %0d", i), ioctl_wait, (i >= 3));
         check($sformatf("stall overflow after write %0d", i), overflow, (i >= 5));
      end
      ticks(20);
      check("stall req held", sdr_req, 1'b1);
      auto_ack = 1'b1;
      wait_done("stall");

      // Push and pop in the same cycle while full
      auto_ack = 1'b0;
      start_dl(3);
      for (int i = 0; i < 5; i++) write(27'h0000200 + 27'(2 * i), 16'($urandom), 1'b1);
      check("full wait", ioctl_wait, 1'b1);
      check("full no overflow", overflow, 1'b0);
      check("full req", sdr_req, 1'b1);
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      check("full req gap after ack", sdr_req, 1'b0);
      write(27'h0000300, 16'h1234, 1'b1);
      check("push+pop no overflow", overflow, 1'b0);
      check("push+pop req reloaded", sdr_req, 1'b1);
      check("push+pop still full", ioctl_wait, 1'b1);
      write(27'h0000302, 16'h5678, 1'b0);
      check("push at full sets overflow", overflow, 1'b1);
      auto_ack = 1'b1;
      wait_done("pushpop");

      // Range errors
      start_dl(5);
      write(27'h0000000, 16'hAAAA, 1'b0);
      write(27'h0000002, 16'hBBBB, 1'b0);
      ticks(3);
      check("bad index no req", sdr_req, 1'b0);
      check("bad index range_err", range_err, 1'b1);
      wait_done("badidx");
      start_dl(0);
      write(27'h03FFFFE, 16'hC0DE, 1'b1);
      ticks(2);
      check("last in-range word ok", range_err, 1'b0);
      write(27'h0400000, 16'hDEAD, 1'b0);
      check("addr at RSIZE range_err", range_err, 1'b1);
      write(27'h2000010, 16'hDEAD, 1'b0);
      wait_done("range");

      // Re-download while draining with words pending
      auto_ack = 1'b0;
      start_dl(0);
      for (int i = 0; i < 3; i++) write(27'h0001000 + 27'(2 * i), 16'($urandom), 1'b1);
      ioctl_download = 1'b0;
      tick();
      ticks(2);
      check("drain core_reset", core_reset, 1'b1);
      d0 = done_cnt;
      ioctl_download = 1'b1;
      ioctl_index    = 8'd0;
      tick();
      check("redownload core_reset", core_reset, 1'b1);
      check("redownload req pending", sdr_req, 1'b1);
      write(27'h0002000, 16'h0F0F, 1'b1);
      write(27'h0002002, 16'hF0F0, 1'b1);
      check("no done during redownload", done_cnt, d0);
      auto_ack = 1'b1;
      wait_done("redownload");

      // Reset mid-load with a request pending and 3 words queued
      auto_ack = 1'b0;
      start_dl(1);
      for (int i = 0; i < 4; i++) write(27'h0003000 + 27'(2 * i), 16'($urandom), 1'b1);
      check("midreset req before", sdr_req, 1'b1);
      check("midreset wait before", ioctl_wait, 1'b1);
      d0 = done_cnt;
      reset          = 1'b1;
      ioctl_download = 1'b0;
      tick();
      check_reset_vals("midreset");
      sb.delete();
      reset   = 1'b0;
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      check("late ack ignored", sdr_req, 1'b0);
      ticks(2);
      check("fifo flushed", sdr_req, 1'b0);
      check("no done after reset", done_cnt, d0);
      check("core_reset after reset", core_reset, 1'b0);

      // Randomized downloads, honoring ioctl_wait
      auto_ack = 1'b1;
      for (int t = 0; t < 6; t++) begin
         idx = $urandom_range(0, 4);
         start_dl(idx);
         exp_rerr = 1'b0;
         n = $urandom_range(6, 14);
         for (int i = 0; i < n; i++) begin
            ticks($urandom_range(0, 2));
            wait_no_wait();
            a = 27'($urandom);
            a[26:22] = 5'b00000;
            r = $urandom_range(0, 7);
            if (r == 0) a[22] = 1'b1;
            if (r == 1) a[25] = 1'b1;
            keep = in_range(idx, a);
            if (!keep) exp_rerr = 1'b1;
            write(a, 16'($urandom), keep);
         end
         check($sformatf("random %0d range_err", t), range_err, exp_rerr);
         check($sformatf("random %0d overflow", t), overflow, 1'b0);
         wait_done($sformatf("random %0d", t));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
